// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, ExcCode values and SR/Cause field positions.
package cp0_pkg;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_BD    = 31;
endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: pipeline <-> CP0 signal bundle; the pipeline is master, CP0 is slave.
interface cp0_unit_if;
  logic [4:0]  A;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntExcReq;
  logic [31:0] EPC;
  modport master (output A, WE, DIn, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
                  input DOut, IntExcReq, EPC);
  modport slave (input A, WE, DIn, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
                 output DOut, IntExcReq, EPC);
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-pending flag.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        pend_q, pend_d;
  always_comb begin
    count_d   = cnt_we_i ? din_i : count_q + 32'd1;
    compare_d = cmp_we_i ? din_i : compare_q;
    pend_d    = cmp_we_i ? 1'b0 : pend_q | (count_q == compare_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end
  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pend_o    = pend_q;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 - SR/Cause/EPC/PRId, exception and interrupt request.
// Define CP0_COUNT_EN to add Count/Compare with the timer interrupt on HWInt[5].
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2020,
  parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
  input logic     clk,
  input logic     reset,
  cp0_unit_if.slave bus
);
  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_e;
  state_e      state_q, state_d;
  logic [5:0]  im_q, im_d, ip_q, ip_d, hwint;
  logic        ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d, sr_val, cause_val;
  logic        int_req, exc_req, req, sr_wr, epc_wr;
`ifdef CP0_COUNT_EN
  logic [31:0] count, compare;
  logic        tpend;
  cp0_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .cnt_we_i  (bus.WE && bus.A == REG_COUNT && !req),
    .cmp_we_i  (bus.WE && bus.A == REG_COMPARE && !req),
    .din_i     (bus.DIn),
    .count_o   (count),
    .compare_o (compare),
    .pend_o    (tpend)
  );
  assign hwint = bus.HWInt | {tpend, 5'b0};
`else
  assign hwint = bus.HWInt;
`endif
  assign int_req = ie_q && state_q == NORMAL && |(hwint & im_q);
  assign exc_req = |bus.ExcCodeIn && state_q == NORMAL;
  assign req     = int_req | exc_req;
  assign sr_wr   = bus.WE && bus.A == REG_SR && !req;
  assign epc_wr  = bus.WE && bus.A == REG_EPC && !req;
  always_comb begin
    im_d    = sr_wr ? bus.DIn[SR_IM_LO +: 6] : im_q;
    ie_d    = sr_wr ? bus.DIn[SR_IE] : ie_q;
    state_d = req ? HANDLER :
              bus.EXLClr ? NORMAL :
              sr_wr ? state_e'(bus.DIn[SR_EXL]) : state_q;
    bd_d    = req ? bus.BDIn : bd_q;
    exc_d   = req ? (int_req ? EXC_INT : bus.ExcCodeIn) : exc_q;
    ip_d    = hwint;
    epc_d   = req ? (bus.PC - (bus.BDIn ? 32'd4 : 32'd0)) & 32'hFFFF_FFFC :
              epc_wr ? bus.DIn & 32'hFFFF_FFFC : epc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      im_q    <= '0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      ip_q    <= '0;
      epc_q   <= EPC_RESET;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
    end
  end
  assign sr_val    = {16'b0, im_q, 8'b0, state_q == HANDLER, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
  always_comb begin
    bus.DOut = '0;
    case (bus.A)
      REG_SR:    bus.DOut = sr_val;
      REG_CAUSE: bus.DOut = cause_val;
      REG_EPC:   bus.DOut = epc_q;
      REG_PRID:  bus.DOut = PRID_VALUE;
`ifdef CP0_COUNT_EN
      REG_COUNT:   bus.DOut = count;
      REG_COMPARE: bus.DOut = compare;
`endif
      default:   bus.DOut = '0;
    endcase
  end
  assign bus.IntExcReq = req;
  assign bus.EPC       = epc_q;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed, self-checking bench for cp0_unit (default build, no timer).
module tb_cp0_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  cp0_unit_if bus();
  cp0_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic idle();
    bus.A = 5'd0; bus.WE = 1'b0; bus.DIn = '0; bus.PC = 32'h0000_3000;
    bus.BDIn = 1'b0; bus.ExcCodeIn = '0; bus.HWInt = '0; bus.EXLClr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.A = a; bus.WE = 1'b1; bus.DIn = d;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    repeat (2) step();
    reset = 1'b1;
    mtc0(5'd12, 32'h0000_FC03);
    bus.WE = 1'b1; bus.A = 5'd12; bus.DIn = 32'hFFFF_FFFF;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.DOut !== 32'h0) begin failures++; $display("FAIL reset_sr got=%h exp=%h", bus.DOut, 32'h0); end
    checks++; if (bus.IntExcReq !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.IntExcReq); end
    checks++; if (bus.EPC !== 32'h0000_3000) begin failures++; $display("FAIL reset_epc got=%h exp=%h", bus.EPC, 32'h0000_3000); end
    step();
    bus.A = 5'd15; #1;
    checks++; if (bus.DOut !== 32'h0000_2020) begin failures++; $display("FAIL reset_prid got=%h exp=%h", bus.DOut, 32'h0000_2020); end
    bus.A = 5'd12; #1;
    checks++; if (bus.DOut !== 32'h0) begin failures++; $display("FAIL reset_sr_held got=%h exp=0", bus.DOut); end
    bus.A = 5'd13; #1;
    checks++; if (bus.DOut !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", bus.DOut); end
    idle();
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  task automatic test_interrupt();
    bus.HWInt = 6'b000100; bus.PC = 32'h0000_3040;
    bus.A = 5'd12; bus.WE = 1'b1; bus.DIn = 32'h0000_FC01; #1;
    checks++; if (bus.IntExcReq !== 1'b0) begin failures++; $display("FAIL int_before_en got=%b exp=0", bus.IntExcReq); end
    step();
    bus.WE = 1'b0; #1;
    checks++; if (bus.IntExcReq !== 1'b1) begin failures++; $display("FAIL int_req got=%b exp=1", bus.IntExcReq); end
    step();
    bus.A = 5'd13; #1;
    checks++; if (bus.DOut !== 32'h0000_1000) begin failures++; $display("FAIL int_cause got=%h exp=%h", bus.DOut, 32'h0000_1000); end
    bus.A = 5'd12; #1;
    checks++; if (bus.DOut !== 32'h0000_FC03) begin failures++; $display("FAIL int_sr got=%h exp=%h", bus.DOut, 32'h0000_FC03); end
    checks++; if (bus.EPC !== 32'h0000_3040) begin failures++; $display("FAIL int_epc got=%h exp=%h", bus.EPC, 32'h0000_3040); end
    checks++; if (bus.IntExcReq !== 1'b0) begin failures++; $display("FAIL int_masked_exl got=%b exp=0", bus.IntExcReq); end
    bus.HWInt = '0;
  endtask

  task automatic test_exception();
    mtc0(5'd12, 32'h0000_0000);
    bus.ExcCodeIn = 5'd12; bus.BDIn = 1'b1; bus.PC = 32'h0000_3010; #1;
    checks++; if (bus.IntExcReq !== 1'b1) begin failures++; $display("FAIL exc_req got=%b exp=1", bus.IntExcReq); end
    step();
    bus.A = 5'd13; #1;
    checks++; if (bus.DOut !== 32'h8000_0030) begin failures++; $display("FAIL exc_cause got=%h exp=%h", bus.DOut, 32'h8000_0030); end
    checks++; if (bus.EPC !== 32'h0000_300C) begin failures++; $display("FAIL exc_epc_bd got=%h exp=%h", bus.EPC, 32'h0000_300C); end
    bus.PC = 32'h0000_4000; bus.BDIn = 1'b0; #1;
    checks++; if (bus.IntExcReq !== 1'b0) begin failures++; $display("FAIL exc_nested_req got=%b exp=0", bus.IntExcReq); end
    step();
    checks++; if (bus.EPC !== 32'h0000_300C) begin failures++; $display("FAIL exc_nested_epc got=%h exp=%h", bus.EPC, 32'h0000_300C); end
    checks++; if (bus.DOut !== 32'h8000_0030) begin failures++; $display("FAIL exc_nested_cause got=%h exp=%h", bus.DOut, 32'h8000_0030); end
    bus.ExcCodeIn = '0;
  endtask

  task automatic test_priority();
    bus.EXLClr = 1'b1; step(); bus.EXLClr = 1'b0;
    mtc0(5'd12, 32'h0000_FC01);
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd10; bus.PC = 32'h0000_5000;
    bus.A = 5'd14; bus.WE = 1'b1; bus.DIn = 32'h1234_5678; #1;
    checks++; if (bus.IntExcReq !== 1'b1) begin failures++; $display("FAIL prio_req got=%b exp=1", bus.IntExcReq); end
    step();
    bus.WE = 1'b0; bus.ExcCodeIn = '0; bus.A = 5'd13; #1;
    checks++; if (bus.DOut !== 32'h0000_0400) begin failures++; $display("FAIL prio_cause got=%h exp=%h", bus.DOut, 32'h0000_0400); end
    checks++; if (bus.EPC !== 32'h0000_5000) begin failures++; $display("FAIL prio_epc_suppress got=%h exp=%h", bus.EPC, 32'h0000_5000); end
  endtask

  task automatic test_eret();
    bus.PC = 32'h0000_6000; bus.EXLClr = 1'b1; #1;
    checks++; if (bus.IntExcReq !== 1'b0) begin failures++; $display("FAIL eret_same_cycle got=%b exp=0", bus.IntExcReq); end
    step();
    bus.EXLClr = 1'b0; #1;
    checks++; if (bus.IntExcReq !== 1'b1) begin failures++; $display("FAIL eret_next_cycle got=%b exp=1", bus.IntExcReq); end
    step();
    checks++; if (bus.EPC !== 32'h0000_6000) begin failures++; $display("FAIL eret_retake_epc got=%h exp=%h", bus.EPC, 32'h0000_6000); end
    bus.HWInt = '0; bus.EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_8403);
    bus.EXLClr = 1'b0; bus.A = 5'd12; #1;
    checks++; if (bus.DOut !== 32'h0000_8401) begin failures++; $display("FAIL eret_mtc0_sr got=%h exp=%h", bus.DOut, 32'h0000_8401); end
  endtask

  task automatic test_mtc0_misc();
    bus.A = 5'd14; bus.WE = 1'b1; bus.DIn = 32'hABCD_0007; #1;
    checks++; if (bus.DOut !== 32'h0000_6000) begin failures++; $display("FAIL no_bypass got=%h exp=%h", bus.DOut, 32'h0000_6000); end
    step();
    bus.WE = 1'b0; #1;
    checks++; if (bus.DOut !== 32'hABCD_0004) begin failures++; $display("FAIL epc_write got=%h exp=%h", bus.DOut, 32'hABCD_0004); end
    checks++; if (bus.EPC !== 32'hABCD_0004) begin failures++; $display("FAIL epc_port got=%h exp=%h", bus.EPC, 32'hABCD_0004); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    bus.A = 5'd13; #1;
    checks++; if (bus.DOut !== 32'h0000_0000) begin failures++; $display("FAIL cause_ro got=%h exp=%h", bus.DOut, 32'h0000_0000); end
    mtc0(5'd15, 32'hFFFF_FFFF);
    bus.A = 5'd15; #1;
    checks++; if (bus.DOut !== 32'h0000_2020) begin failures++; $display("FAIL prid_ro got=%h exp=%h", bus.DOut, 32'h0000_2020); end
    mtc0(5'd9, 32'h1234_0000);
    bus.A = 5'd9; #1;
    checks++; if (bus.DOut !== 32'h0) begin failures++; $display("FAIL count_absent got=%h exp=0", bus.DOut); end
    bus.A = 5'd12; #1;
    checks++; if (bus.DOut !== 32'h0000_8401) begin failures++; $display("FAIL sr_kept got=%h exp=%h", bus.DOut, 32'h0000_8401); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_eret();
    test_mtc0_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
